// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one sequential signed multiplier among NREQ requesters.
// The winner's operands are held on the multiplier for the whole operation, with a watchdog abort.
module mult_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_in,
  input  logic [NREQ*W-1:0] b_in,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              err,
  output logic [2*W-1:0]    p_out,
  output logic              busy,
  output logic              mul_start,
  output logic [W-1:0]      mul_a,
  output logic [W-1:0]      mul_b,
  input  logic [2*W-1:0]    mul_p,
  input  logic              mul_rdy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   owner;
  logic [CW-1:0]   wcnt;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   cand;

  // Scan downward so the last hit is the first requester at or above ptr.
  always_comb begin
    pick = ptr;
    cand = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr) + k) % NREQ);
      if (req[cand]) pick = cand;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      wcnt      <= '0;
      gnt       <= '0;
      done      <= '0;
      err       <= 1'b0;
      p_out     <= '0;
      busy      <= 1'b0;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            owner     <= pick;
            mul_a     <= a_in[int'(pick)*W +: W];
            mul_b     <= b_in[int'(pick)*W +: W];
            gnt       <= NREQ'(1) << pick;
            mul_start <= 1'b1;
            busy      <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          mul_start <= 1'b0;
          wcnt      <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          wcnt <= wcnt + CW'(1);
          // rdy in the first WAIT cycle may be stale from the previous operation
          if (mul_rdy && (wcnt != '0)) begin
            p_out <= mul_p;
            done  <= NREQ'(1) << owner;
            err   <= 1'b0;
            state <= DONE;
          end else if (wcnt == CW'(TIMEOUT - 1)) begin
            p_out <= '0;
            done  <= NREQ'(1) << owner;
            err   <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= '0;
          err   <= 1'b0;
          gnt   <= '0;
          busy  <= 1'b0;
          ptr   <= (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Scoreboard bench for mult_share_arbiter with a behavioural sequential multiplier model.
// Expected completions are queued as requests are raised and checked as done pulses appear.
module tb_mult_share_arbiter;

  localparam int NREQ    = 4;
  localparam int W       = 8;
  localparam int TIMEOUT = 31;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_in;
  logic [NREQ*W-1:0] b_in;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic              err;
  logic [2*W-1:0]    p_out;
  logic              busy;
  logic              mul_start;
  logic [W-1:0]      mul_a;
  logic [W-1:0]      mul_b;
  logic [2*W-1:0]    mul_p;
  logic              mul_rdy;

  mult_share_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .done(done), .err(err), .p_out(p_out), .busy(busy),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_p(mul_p), .mul_rdy(mul_rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          owner;
    logic [15:0] p;
    logic        err;
    int          lat;
    int          gap;
    logic [7:0]  a;
    logic [7:0]  b;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic rdyKill = 1'b0;
  logic rdyStuck = 1'b0;
  logic autoDrop = 1'b1;

  // Multiplier stand-in: start clears it, rdy rises so that it is sampled 18 edges after start falls.
  logic [4:0]         mcnt;
  logic signed [15:0] sa;
  logic signed [15:0] sbx;
  logic signed [15:0] prod;

  always @(posedge clk or posedge mul_start or posedge reset) begin
    if (reset || mul_start) mcnt <= 5'd0;
    else if (mcnt != 5'd31) mcnt <= mcnt + 5'd1;
  end

  assign sa      = 16'($signed(mul_a));
  assign sbx     = 16'($signed(mul_b));
  assign prod    = sa * sbx;
  assign mul_rdy = rdyStuck | (!rdyKill && !mul_start && (mcnt >= 5'd17));
  assign mul_p   = mul_rdy ? prod : 16'hDEAD;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] expProd(input logic [7:0] a, input logic [7:0] b);
    int ia;
    int ib;
    ia = int'($signed(a));
    ib = int'($signed(b));
    return 16'(ia * ib);
  endfunction

  task automatic applyStimulus(input int owner, input logic [7:0] a, input logic [7:0] b,
                               input logic isErr, input int lat, input int gap);
    exp_t e;
    a_in[owner*W +: W] = a;
    b_in[owner*W +: W] = b;
    e.owner = owner;
    e.p     = isErr ? 16'h0000 : expProd(a, b);
    e.err   = isErr;
    e.lat   = lat;
    e.gap   = gap;
    e.a     = a;
    e.b     = b;
    sb.push_back(e);
    req[owner] = 1'b1;
  endtask

  task automatic waitDones(input int n);
    int seen = 0;
    int c = 0;
    while (seen < n && c < n * 40 + 40) begin
      @(negedge clk);
      c++;
      if (done != '0) begin
        seen++;
        if (autoDrop) req = req & ~done;
      end
    end
    checkOutput("dones_seen", 32'(seen), 32'(n));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_gnt"}, 32'(gnt), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_err"}, 32'(err), 32'd0);
    checkOutput({tag, "_p_out"}, 32'(p_out), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_mul_start"}, 32'(mul_start), 32'd0);
    checkOutput({tag, "_mul_a"}, 32'(mul_a), 32'd0);
    checkOutput({tag, "_mul_b"}, 32'(mul_b), 32'd0);
  endtask

  // Monitor: checks grants against the queue head and retires entries on done pulses.
  initial begin
    exp_t            e;
    int              cyc = 0;
    int              grantCyc = 0;
    int              prevDoneCyc = 0;
    int              startCnt = 0;
    logic [NREQ-1:0] prevGnt = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        prevGnt = '0;
      end else begin
        if (gnt != '0 && prevGnt == '0) begin
          if (sb.size() == 0) begin
            checkOutput("gnt_unexpected", 32'(gnt), 32'd0);
          end else begin
            checkOutput("gnt", 32'(gnt), 32'(1) << sb[0].owner);
            checkOutput("busy", 32'(busy), 32'd1);
            checkOutput("mul_a", 32'(mul_a), 32'(sb[0].a));
            checkOutput("mul_b", 32'(mul_b), 32'(sb[0].b));
          end
          grantCyc = cyc;
          startCnt = 0;
        end
        if (mul_start) startCnt++;
        if (done != '0) begin
          if (sb.size() == 0) begin
            checkOutput("done_unexpected", 32'(done), 32'd0);
          end else begin
            e = sb.pop_front();
            checkOutput("done", 32'(done), 32'(1) << e.owner);
            checkOutput("gnt_at_done", 32'(gnt), 32'(done));
            checkOutput("p_out", 32'(p_out), 32'(e.p));
            checkOutput("err", 32'(err), 32'(e.err));
            checkOutput("latency", 32'(cyc - grantCyc), 32'(e.lat));
            checkOutput("start_pulses", 32'(startCnt), 32'd1);
            if (e.gap != 0) checkOutput("done_gap", 32'(cyc - prevDoneCyc), 32'(e.gap));
          end
          prevDoneCyc = cyc;
        end
        prevGnt = gnt;
      end
    end
  end

  initial begin
    req   = '0;
    a_in  = '0;
    b_in  = '0;
    reset = 1'b1;
    @(negedge clk);
    checkAllZero("reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // single request; operand changes while granted must not matter
    applyStimulus(0, 8'd7, 8'd6, 1'b0, 19, 0);
    repeat (6) @(negedge clk);
    a_in[7:0] = 8'h55;
    b_in[7:0] = 8'h11;
    waitDones(1);

    // signed operands on requester 3 (pointer ends at 0)
    applyStimulus(3, 8'hFD, 8'd5, 1'b0, 19, 0);
    waitDones(1);
    applyStimulus(3, 8'h80, 8'h80, 1'b0, 19, 0);
    waitDones(1);

    // contention with all requests held: 0,1,2,3,0
    autoDrop = 1'b0;
    applyStimulus(0, 8'd3, 8'd4, 1'b0, 19, 0);
    applyStimulus(1, 8'hF6, 8'd10, 1'b0, 19, 21);
    applyStimulus(2, 8'd127, 8'h81, 1'b0, 19, 21);
    applyStimulus(3, 8'hFF, 8'hFF, 1'b0, 19, 21);
    applyStimulus(0, 8'd3, 8'd4, 1'b0, 19, 21);
    waitDones(5);

    // pointer wrap with req=1001: 3,0,3
    req = 4'b1001;
    applyStimulus(3, 8'hFF, 8'hFF, 1'b0, 19, 21);
    applyStimulus(0, 8'd3, 8'd4, 1'b0, 19, 21);
    applyStimulus(3, 8'hFF, 8'hFF, 1'b0, 19, 21);
    waitDones(3);
    req = '0;
    autoDrop = 1'b1;

    // watchdog timeout, then a normal operation
    rdyKill = 1'b1;
    applyStimulus(1, 8'd9, 8'd9, 1'b1, 32, 0);
    waitDones(1);
    rdyKill = 1'b0;
    applyStimulus(2, 8'hFE, 8'd7, 1'b0, 19, 21);
    waitDones(1);

    // rdy stuck high: accepted in the second WAIT cycle at the earliest
    rdyStuck = 1'b1;
    applyStimulus(0, 8'd12, 8'd12, 1'b0, 3, 0);
    waitDones(1);
    rdyStuck = 1'b0;

    // reset in the middle of an operation
    a_in[7:0] = 8'd5;
    b_in[7:0] = 8'hF9;
    req[0] = 1'b1;
    applyStimulus(2, 8'd20, 8'd3, 1'b0, 19, 0);
    repeat (8) @(negedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    sb.delete();
    #1 checkAllZero("midreset");
    repeat (3) begin
      @(negedge clk);
      checkOutput("midreset_hold_done", 32'(done), 32'd0);
    end
    applyStimulus(0, 8'd5, 8'hF9, 1'b0, 19, 0);
    applyStimulus(2, 8'd20, 8'd3, 1'b0, 19, 21);
    reset = 1'b0;
    waitDones(2);
    repeat (3) @(negedge clk);
    checkOutput("final_idle_busy", 32'(busy), 32'd0);
    checkOutput("queue_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Shares one 8-bit two's-complement sequential multiplier among NREQ requesters using round-robin arbitration.
- Holds the requester's operands stable on the multiplier inputs for the whole operation.
- The multiplier's asynchronous `reset` port is its start; this block drives it with a one-cycle registered `mul_start` pulse.
- Waits for the multiplier's `rdy`, returns the 16-bit product to the granted requester, and flags a watchdog timeout.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 8, operand width; product width is 2*W.
- TIMEOUT, 31, maximum WAIT cycles before aborting (must exceed 17).

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- req  in  NREQ  per-requester request; held high until its done pulse.
- a_in  in  NREQ*W  packed multiplier operands; requester i uses bits [i*W +: W].
- b_in  in  NREQ*W  packed multiplicand operands, same packing.
- gnt  out  NREQ  one-hot, high for the current owner from START through DONE.
- done  out  NREQ  one-hot, one-cycle completion pulse to the owner.
- err  out  1  high together with done when the operation timed out.
- p_out  out  2*W  product for the done pulse; held until the next DONE.
- busy  out  1  high in any state except IDLE.
- mul_start  out  1  drives the multiplier's start/reset input.
- mul_a  out  W  multiplier operand a.
- mul_b  out  W  multiplier operand b.
- mul_p  in  2*W  multiplier product.
- mul_rdy  in  1  multiplier ready.

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, gnt=0, done=0, err=0, p_out=0, busy=0, mul_start=0, mul_a=0, mul_b=0, rr pointer=0, wait counter=0.
- Reset mid-operation aborts immediately. No done is issued and the pointer returns to 0.
- FSM states: IDLE, START, WAIT, DONE.
- IDLE: if req≠0, select the first set bit scanning from ptr upward, wrapping modulo NREQ. On that edge:
  - latch the owner index;
  - set mul_a/mul_b from that requester's a_in/b_in slices;
  - set gnt one-hot and mul_start=1;
  - go to START.
  - If req=0, stay in IDLE.
- START: lasts exactly one cycle with mul_start=1. Next edge: mul_start=0, wait counter=0, go to WAIT.
- WAIT:
  - The wait counter increments every cycle.
  - If mul_rdy=1 and counter≥1 (the first WAIT cycle's rdy is ignored): p_out<=mul_p, done[owner]<=1, err<=0, go to DONE.
  - Else if counter==TIMEOUT-1: p_out<=0, done[owner]<=1, err<=1, go to DONE.
- DONE: lasts one cycle. Next edge:
  - done<=0, err<=0, gnt<=0;
  - ptr<=(owner+1) mod NREQ;
  - go to IDLE.
- Requester protocol:
  - A requester drops req on the edge after it sees done.
  - Changes to req, a_in or b_in while granted are ignored; the operation completes and done still pulses.
- Timing with a compliant multiplier: the multiplier asserts rdy 18 edges after mul_start falls. For a grant edge E0:
  - mul_start is high E0→E1;
  - rdy is sampled at E19;
  - done is high E19→E20;
  - the next grant is possible at E21 (one IDLE cycle).
- Operand slicing: a_in/b_in are passed unmodified. Sign handling belongs to the multiplier, and p_out is its 16-bit two's-complement result.
- Simultaneous requests: only one grant per arbitration. Losers keep req high and are served in round-robin order with no starvation; worst-case wait is NREQ-1 operations.
- A mul_rdy glitch during START is ignored.
- A mul_rdy stuck high is never accepted before the second WAIT cycle.

Test Plan:
- Single request: req=0001, a0=8'd7, b0=8'd6 → gnt=0001, one mul_start pulse, done=0001 19 cycles after grant, p_out=16'd42, err=0.
- Signed operands: a1=8'hFD (-3), b1=8'd5 → p_out=16'hFFF1 (-15). Then a1=8'h80, b1=8'h80 → p_out=16'h4000.
- Contention: req=1111 held continuously → grants in order 0,1,2,3,0. Each done is separated by 21 cycles, and each p_out matches its requester's operands.
- Pointer wrap: after owner 3 completes with req=1001, owner 0 is granted. After owner 0 completes, with the same req=1001, owner 3 is granted.
- Timeout: mul_rdy forced 0 → done pulses after TIMEOUT=31 WAIT cycles with err=1, p_out=0. The next request then proceeds normally.
- Reset mid-operation: assert reset during WAIT → all outputs return to zero immediately and no done is issued. After release, the pending req is granted starting from requester 0.
